// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator. Walks a (drawX, drawY) counter pair
// over an H_TOTAL x V_TOTAL raster and derives sync, active-video and
// line/frame strobes from it. hs/vs/active_nblank can be delayed by
// PIPE_STAGES enabled advances so they line up with a downstream pixel pipe.
//
// Ports
//   pixel_clk      in   pixel clock
//   reset_n        in   asynchronous reset, active low
//   pix_en         in   advance enable; low = counters, pipe and frame_cnt hold
//   restart        in   synchronous jump to (0,0); wins over pix_en
//   hs, vs         out  sync outputs (polarity H_POL/V_POL), delayed PIPE_STAGES
//   active_nblank  out  active video, delayed PIPE_STAGES
//   sync           out  composite sync, tied 0
//   drawX, drawY   out  current column / line (undelayed)
//   line_start     out  one-cycle pulse when drawX became 0
//   frame_start    out  one-cycle pulse when (drawX,drawY) became (0,0)
//   frame_cnt      out  frames started since reset (first one not counted), wraps
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          H_POL       = 1'b0,
  parameter bit          V_POL       = 1'b0,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned PIPE_STAGES = 0,
  parameter int unsigned FRAME_W     = 16
) (
  input  logic               pixel_clk,
  input  logic               reset_n,
  input  logic               pix_en,
  input  logic               restart,
  output logic               hs,
  output logic               vs,
  output logic               active_nblank,
  output logic               sync,
  output logic [COORD_W-1:0] drawX,
  output logic [COORD_W-1:0] drawY,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  if ((H_TOTAL > (32'd1 << COORD_W)) || (V_TOTAL > (32'd1 << COORD_W))) begin : g_bad_coord_w
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
  end
  if (PIPE_STAGES > 8) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_STAGES must be 0..8");
  end

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               started_q, started_d;
  logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic               advance;

  assign advance = pix_en | restart;

  // Counter lookahead and strobes.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (restart) begin
      x_d           = '0;
      y_d           = '0;
      line_start_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + COORD_W'(1);
        end
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // The wrap out of reset lands on (0,0) but is not a completed frame, so the
  // first frame_start after reset leaves frame_cnt at 0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    started_d   = started_q;
    if (frame_start_d) begin
      started_d = 1'b1;
      if (started_q) frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  // Raw terms evaluated on the next counter values, so the registered copy
  // matches the current drawX/drawY with no added latency.
  always_comb begin
    logic [31:0] xn, yn;
    xn   = 32'(x_d);
    yn   = 32'(y_d);
    de_d = (xn < H_ACTIVE) && (yn < V_ACTIVE);
    hs_d = ((xn >= HS_START) && (xn < HS_END)) ? H_POL : ~H_POL;
    vs_d = ((yn >= VS_START) && (yn < VS_END)) ? V_POL : ~V_POL;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      started_q     <= 1'b0;
      de_q          <= 1'b0;
      hs_q          <= ~H_POL;
      vs_q          <= ~V_POL;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      started_q     <= started_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  if (PIPE_STAGES == 0) begin : g_no_pipe
    assign active_nblank = de_q;
    assign hs            = hs_q;
    assign vs            = vs_q;
  end else begin : g_pipe
    // Shift chain: bit 0 of each *_chain is the undelayed term, the shift
    // register holds the previous PIPE_STAGES enabled samples.
    logic [PIPE_STAGES-1:0] de_sh_q, hs_sh_q, vs_sh_q;
    logic [PIPE_STAGES:0]   de_chain, hs_chain, vs_chain;

    assign de_chain = {de_sh_q, de_q};
    assign hs_chain = {hs_sh_q, hs_q};
    assign vs_chain = {vs_sh_q, vs_q};

    always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
        de_sh_q <= '0;
        hs_sh_q <= {PIPE_STAGES{~H_POL}};
        vs_sh_q <= {PIPE_STAGES{~V_POL}};
      end else if (advance) begin
        de_sh_q <= de_chain[PIPE_STAGES-1:0];
        hs_sh_q <= hs_chain[PIPE_STAGES-1:0];
        vs_sh_q <= vs_chain[PIPE_STAGES-1:0];
      end
    end

    assign active_nblank = de_sh_q[PIPE_STAGES-1];
    assign hs            = hs_sh_q[PIPE_STAGES-1];
    assign vs            = vs_sh_q[PIPE_STAGES-1];
  end

  assign sync        = 1'b0;
  assign drawX       = x_q;
  assign drawY       = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances of vga_timing_gen sharing clock, reset and stimulus:
//   dut0  default 640x480 mode, PIPE_STAGES=0
//   dut1  80x56 raster (64/4/8/4 x 48/2/2/4), H_POL=V_POL=1, PIPE_STAGES=3
//   dut2  8x6 raster (4/1/2/1 x 3/1/1/1), FRAME_W=2, PIPE_STAGES=1
// A raster model tracks each instance as a linear pixel index and keeps a
// history of raw terms per enabled advance; every falling edge all outputs of
// all instances are compared with it. Directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int C_HA   [3] = '{640, 64, 4};
  localparam int C_HF   [3] = '{16,  4,  1};
  localparam int C_HS   [3] = '{96,  8,  2};
  localparam int C_HB   [3] = '{48,  4,  1};
  localparam int C_VA   [3] = '{480, 48, 3};
  localparam int C_VF   [3] = '{10,  2,  1};
  localparam int C_VS   [3] = '{2,   2,  1};
  localparam int C_VB   [3] = '{33,  4,  1};
  localparam int C_POL  [3] = '{0,   1,  0};
  localparam int C_PIPE [3] = '{0,   3,  1};
  localparam int C_FW   [3] = '{16,  16, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic restart = 1'b0;

  always #5 clk = ~clk;

  logic        d0_hs, d0_vs, d0_de, d0_sy, d0_ls, d0_fs;
  logic [9:0]  d0_x, d0_y;
  logic [15:0] d0_fc;
  logic        d1_hs, d1_vs, d1_de, d1_sy, d1_ls, d1_fs;
  logic [6:0]  d1_x, d1_y;
  logic [15:0] d1_fc;
  logic        d2_hs, d2_vs, d2_de, d2_sy, d2_ls, d2_fs;
  logic [2:0]  d2_x, d2_y;
  logic [1:0]  d2_fc;

  vga_timing_gen u_dut0 (
    .pixel_clk(clk), .reset_n(rst_n), .pix_en(pix_en), .restart(restart),
    .hs(d0_hs), .vs(d0_vs), .active_nblank(d0_de), .sync(d0_sy),
    .drawX(d0_x), .drawY(d0_y), .line_start(d0_ls), .frame_start(d0_fs),
    .frame_cnt(d0_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .H_POL(1'b1), .V_POL(1'b1), .COORD_W(7), .PIPE_STAGES(3), .FRAME_W(16)
  ) u_dut1 (
    .pixel_clk(clk), .reset_n(rst_n), .pix_en(pix_en), .restart(restart),
    .hs(d1_hs), .vs(d1_vs), .active_nblank(d1_de), .sync(d1_sy),
    .drawX(d1_x), .drawY(d1_y), .line_start(d1_ls), .frame_start(d1_fs),
    .frame_cnt(d1_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .COORD_W(3), .PIPE_STAGES(1), .FRAME_W(2)
  ) u_dut2 (
    .pixel_clk(clk), .reset_n(rst_n), .pix_en(pix_en), .restart(restart),
    .hs(d2_hs), .vs(d2_vs), .active_nblank(d2_de), .sync(d2_sy),
    .drawX(d2_x), .drawY(d2_y), .line_start(d2_ls), .frame_start(d2_fs),
    .frame_cnt(d2_fc)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- raster model ----------------
  int         m_x [3];
  int         m_y [3];
  int         m_fc [3];
  bit         m_started [3];
  bit         m_ls [3];
  bit         m_fs [3];
  logic [2:0] m_hist [3][9];   // {de, hs, vs}; [0] = current position

  function automatic logic [2:0] raw(input int i, input int x, input int y);
    logic de, h, v;
    de = (x < C_HA[i]) && (y < C_VA[i]);
    h  = (x >= C_HA[i] + C_HF[i] && x < C_HA[i] + C_HF[i] + C_HS[i]) ? (C_POL[i] != 0) : (C_POL[i] == 0);
    v  = (y >= C_VA[i] + C_VF[i] && y < C_VA[i] + C_VF[i] + C_VS[i]) ? (C_POL[i] != 0) : (C_POL[i] == 0);
    return {de, h, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_x[i] = C_HA[i] + C_HF[i] + C_HS[i] + C_HB[i] - 1;
      m_y[i] = C_VA[i] + C_VF[i] + C_VS[i] + C_VB[i] - 1;
      m_fc[i] = 0;
      m_started[i] = 1'b0;
      m_ls[i] = 1'b0;
      m_fs[i] = 1'b0;
      for (int k = 0; k < 9; k++) m_hist[i][k] = {1'b0, C_POL[i] == 0, C_POL[i] == 0};
    end
  endtask

  task automatic model_step(input logic en, input logic rs);
    for (int i = 0; i < 3; i++) begin
      int ht, vt, p;
      ht = C_HA[i] + C_HF[i] + C_HS[i] + C_HB[i];
      vt = C_VA[i] + C_VF[i] + C_VS[i] + C_VB[i];
      m_ls[i] = 1'b0;
      m_fs[i] = 1'b0;
      if (rs) begin
        m_x[i] = 0; m_y[i] = 0; m_ls[i] = 1'b1; m_fs[i] = 1'b1;
      end else if (en) begin
        p = (m_y[i] * ht + m_x[i] + 1) % (ht * vt);
        m_x[i] = p % ht;
        m_y[i] = p / ht;
        m_ls[i] = (m_x[i] == 0);
        m_fs[i] = (p == 0);
      end
      if (rs || en) begin
        for (int k = 8; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = raw(i, m_x[i], m_y[i]);
      end
      if (m_fs[i]) begin
        if (m_started[i]) m_fc[i] = (m_fc[i] + 1) % (1 << C_FW[i]);
        m_started[i] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step(pix_en, restart);
  end

  // ---------------- comparison ----------------
  function automatic logic [41:0] pk(input int fc, input int x, input int y,
                                     input logic h, input logic v, input logic de,
                                     input logic ls, input logic fs, input logic sy);
    return {16'(fc), 10'(x), 10'(y), h, v, de, ls, fs, sy};
  endfunction

  task automatic cmp_dut(input int i, input logic [41:0] act);
    logic [2:0]  e;
    logic [41:0] exp_v;
    e = m_hist[i][C_PIPE[i]];
    exp_v = pk(m_fc[i], m_x[i], m_y[i], e[1], e[0], e[2], m_ls[i], m_fs[i], 1'b0);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL model_dut%0d t=%0t actual fc/x/y/hs/vs/de/ls/fs/sync=%h required=%h",
               i, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    cmp_dut(0, pk(int'(d0_fc), int'(d0_x), int'(d0_y), d0_hs, d0_vs, d0_de, d0_ls, d0_fs, d0_sy));
    cmp_dut(1, pk(int'(d1_fc), int'(d1_x), int'(d1_y), d1_hs, d1_vs, d1_de, d1_ls, d1_fs, d1_sy));
    cmp_dut(2, pk(int'(d2_fc), int'(d2_x), int'(d2_y), d2_hs, d2_vs, d2_de, d2_ls, d2_fs, d2_sy));
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp_v);
    end
  endtask

  // ---------------- stimulus and directed checks ----------------
  initial begin
    int first_lo, last_lo, de1_rise, hs1_rise_x, vs1_y50, vs1_y49, exp_fc, n;
    bit prev_de1, prev_hs1, fc2_wrap, fs1_origin;
    int prev_fc2;
    int fsq[$];

    rst_n = 1'b0; pix_en = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x0", int'(d0_x), 799);
    check("rst_y0", int'(d0_y), 524);
    check("rst_hs0", int'(d0_hs), 1);
    check("rst_vs0", int'(d0_vs), 1);
    check("rst_de0", int'(d0_de), 0);
    check("rst_fc0", int'(d0_fc), 0);
    check("rst_hs1", int'(d1_hs), 0);
    check("rst_x2", int'(d2_x), 7);
    check("rst_y2", int'(d2_y), 5);

    #1 rst_n = 1'b1; pix_en = 1'b1;
    @(negedge clk);
    check("edge1_x0", int'(d0_x), 0);
    check("edge1_y0", int'(d0_y), 0);
    check("edge1_fs0", int'(d0_fs), 1);
    check("edge1_ls0", int'(d0_ls), 1);
    check("edge1_de0", int'(d0_de), 1);
    check("edge1_fc0", int'(d0_fc), 0);
    check("edge1_de1_pipe", int'(d1_de), 0);

    // Free-running: two full frames of dut1.
    first_lo = -1; last_lo = -1; de1_rise = -1; hs1_rise_x = -1;
    vs1_y50 = -1; vs1_y49 = -1; prev_de1 = 1'b0; prev_hs1 = 1'b0;
    fc2_wrap = 1'b0; fs1_origin = 1'b1; prev_fc2 = 0;
    for (int c = 1; c <= 8980; c++) begin
      if (d0_y == 0 && d0_hs == 1'b0) begin
        if (first_lo < 0) first_lo = int'(d0_x);
        last_lo = int'(d0_x);
      end
      if (d1_fs) begin
        fsq.push_back(c);
        if (d1_x != 0 || d1_y != 0) fs1_origin = 1'b0;
      end
      if (d1_de && !prev_de1 && de1_rise < 0) de1_rise = c;
      if (d1_hs && !prev_hs1 && hs1_rise_x < 0) hs1_rise_x = int'(d1_x);
      if (d1_x == 10 && d1_y == 50) vs1_y50 = int'(d1_vs);
      if (d1_x == 10 && d1_y == 49) vs1_y49 = int'(d1_vs);
      if (d2_fs && prev_fc2 == 3 && d2_fc == 2'd0) fc2_wrap = 1'b1;
      prev_fc2 = int'(d2_fc);
      prev_de1 = d1_de;
      prev_hs1 = d1_hs;
      @(negedge clk);
    end
    check("hs0_low_first_x", first_lo, 656);
    check("hs0_low_last_x", last_lo, 751);
    check("de1_rise_cycle", de1_rise, 4);
    check("hs1_rise_x", hs1_rise_x, 71);
    check("vs1_at_y50", vs1_y50, 1);
    check("vs1_at_y49", vs1_y49, 0);
    check("fs1_count", fsq.size(), 3);
    if (fsq.size() >= 2) check("frame1_period", fsq[1] - fsq[0], 4480);
    check("fs1_at_origin", int'(fs1_origin), 1);
    check("fc1_after_two_wraps", int'(d1_fc), 2);
    check("fc2_wraps_3_to_0", int'(fc2_wrap), 1);

    // pix_en toggled every cycle: a dut1 frame doubles in length.
    fsq.delete();
    for (int c = 0; c < 18400; c++) begin
      if (d1_fs) fsq.push_back(c);
      #1 pix_en = (c % 2 == 0);
      @(negedge clk);
    end
    if (fsq.size() >= 2) check("toggle_frame1_period", fsq[1] - fsq[0], 8960);
    else check("toggle_fs1_seen", fsq.size(), 2);

    // Random enable with occasional restart; model checks every cycle.
    for (int c = 0; c < 8000; c++) begin
      #1;
      pix_en  = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end

    // Directed restart while pix_en is low.
    #1 pix_en = 1'b1; restart = 1'b0;
    @(negedge clk);
    n = 0;
    while (d0_x != 10'd300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_x300", int'(d0_x), 300);
    exp_fc = (m_fc[0] + (m_started[0] ? 1 : 0)) % 65536;
    #1 restart = 1'b1; pix_en = 1'b0;
    @(negedge clk);
    check("restart_x0", int'(d0_x), 0);
    check("restart_y0", int'(d0_y), 0);
    check("restart_fs0", int'(d0_fs), 1);
    check("restart_ls0", int'(d0_ls), 1);
    check("restart_fc0", int'(d0_fc), exp_fc);
    check("restart_x1", int'(d1_x), 0);
    #1 restart = 1'b0;
    @(negedge clk);
    check("hold_fs0_low", int'(d0_fs), 0);
    check("hold_x0", int'(d0_x), 0);

    // Reset pulsed mid-line on the small raster.
    #1 pix_en = 1'b1;
    n = 0;
    while (d2_x != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_x3_dut2", int'(d2_x), 3);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_x2", int'(d2_x), 7);
    check("midrst_y2", int'(d2_y), 5);
    check("midrst_fc2", int'(d2_fc), 0);
    check("midrst_de2", int'(d2_de), 0);
    check("midrst_hs2", int'(d2_hs), 1);
    check("midrst_x0", int'(d0_x), 799);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #1;
      pix_en  = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
